// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bundle between the MEM stage and the data cache.
interface mem_wb_stage_if;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dcREN;
    logic        dcWEN;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemaddr, dmemstore, dcREN, dcWEN,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemaddr, dmemstore, dcREN, dcWEN,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register.
// Holds a cache request until dhit. If a load completes while MEM/WB is
// frozen, its data is parked in a hold buffer so the access is not re-issued.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    mem_wb_stage_if.master   dc,
    input  logic [31:0]      result_EX_MEM,
    input  logic [31:0]      dmemstore_EX_MEM,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             WEN_EX_MEM,
    input  logic             halt_EX_MEM,
    input  logic [1:0]       reg_dest_EX_MEM,
    input  logic [4:0]       Rt_EX_MEM,
    input  logic [4:0]       Rd_EX_MEM,
    input  logic [31:0]      imemaddr_EX_MEM,
    input  logic [31:0]      instruction_EX_MEM,
    input  logic             enable_MEM_WB,
    input  logic             flush_MEM_WB,
    output logic             stall_MEM,
    output logic [31:0]      wdat_MEM_WB,
    output logic [4:0]       wsel_MEM_WB,
    output logic             WEN_MEM_WB,
    output logic             halt_MEM_WB,
    output logic [31:0]      imemaddr_MEM_WB,
    output logic [31:0]      instruction_MEM_WB,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_buf;
    logic        req;
    logic        capture;
    logic        dc_ren, dc_wen;
    logic [31:0] wdat_nxt;
    logic [4:0]  wsel_nxt;

    // Halted instructions never touch memory.
    assign req          = (dmemREN | dmemWEN) & ~halt_EX_MEM;
    assign dc.dmemaddr  = result_EX_MEM;
    assign dc.dmemstore = dmemstore_EX_MEM;
    assign dc.dcREN     = dc_ren;
    assign dc.dcWEN     = dc_wen;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and cache request; HOLD suppresses the request because the
    // access already completed and its data sits in hold_buf.
    always_comb begin
        state_nxt = state;
        dc_ren    = 1'b0;
        dc_wen    = 1'b0;
        stall_MEM = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE, WAIT: begin
                dc_ren    = dmemREN & req;
                dc_wen    = dmemWEN & req;
                stall_MEM = req & ~dc.dhit;
                if (req && !dc.dhit) begin
                    state_nxt = WAIT;
                end else if (req && dc.dhit && !enable_MEM_WB) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (enable_MEM_WB) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-back data and destination select.
    always_comb begin
        wdat_nxt = result_EX_MEM;
        if (dmemREN) wdat_nxt = (state == HOLD) ? hold_buf : dc.dmemload;
        case (reg_dest_EX_MEM)
            2'd1:    wsel_nxt = Rd_EX_MEM;
            2'd2:    wsel_nxt = 5'd31;
            default: wsel_nxt = Rt_EX_MEM;
        endcase
    end

    // Hold buffer for load data that completed while MEM/WB was frozen.
    always_ff @(posedge CLK) begin
        if (RST)          hold_buf <= '0;
        else if (capture) hold_buf <= dc.dmemload;
    end

    // MEM/WB register: flush beats load; halt is sticky until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdat_MEM_WB        <= '0;
            wsel_MEM_WB        <= '0;
            WEN_MEM_WB         <= 1'b0;
            halt_MEM_WB        <= 1'b0;
            imemaddr_MEM_WB    <= '0;
            instruction_MEM_WB <= '0;
        end else if (flush_MEM_WB) begin
            wdat_MEM_WB        <= '0;
            wsel_MEM_WB        <= '0;
            WEN_MEM_WB         <= 1'b0;
            imemaddr_MEM_WB    <= '0;
            instruction_MEM_WB <= '0;
        end else if (enable_MEM_WB && !stall_MEM) begin
            wdat_MEM_WB        <= wdat_nxt;
            wsel_MEM_WB        <= wsel_nxt;
            WEN_MEM_WB         <= WEN_EX_MEM;
            halt_MEM_WB        <= halt_MEM_WB | halt_EX_MEM;
            imemaddr_MEM_WB    <= imemaddr_EX_MEM;
            instruction_MEM_WB <= instruction_EX_MEM;
        end
    end

    // Saturating count of memory-stall cycles.
    always_ff @(posedge CLK) begin
        if (RST)                               mem_stall_cnt <= '0;
        else if (stall_MEM && !(&mem_stall_cnt)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. Counter is built 2 bits wide so that
// saturation is reachable in a few cycles.
module tb_mem_wb_stage;
    localparam int CNT_W = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [31:0]      result_EX_MEM, dmemstore_EX_MEM;
    logic             dmemREN, dmemWEN, WEN_EX_MEM, halt_EX_MEM;
    logic [1:0]       reg_dest_EX_MEM;
    logic [4:0]       Rt_EX_MEM, Rd_EX_MEM;
    logic [31:0]      imemaddr_EX_MEM, instruction_EX_MEM;
    logic             enable_MEM_WB, flush_MEM_WB;
    logic             stall_MEM;
    logic [31:0]      wdat_MEM_WB;
    logic [4:0]       wsel_MEM_WB;
    logic             WEN_MEM_WB, halt_MEM_WB;
    logic [31:0]      imemaddr_MEM_WB, instruction_MEM_WB;
    logic [CNT_W-1:0] mem_stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    mem_wb_stage_if dc ();

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .dc(dc.master),
        .result_EX_MEM(result_EX_MEM), .dmemstore_EX_MEM(dmemstore_EX_MEM),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .WEN_EX_MEM(WEN_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
        .reg_dest_EX_MEM(reg_dest_EX_MEM), .Rt_EX_MEM(Rt_EX_MEM), .Rd_EX_MEM(Rd_EX_MEM),
        .imemaddr_EX_MEM(imemaddr_EX_MEM), .instruction_EX_MEM(instruction_EX_MEM),
        .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
        .stall_MEM(stall_MEM), .wdat_MEM_WB(wdat_MEM_WB), .wsel_MEM_WB(wsel_MEM_WB),
        .WEN_MEM_WB(WEN_MEM_WB), .halt_MEM_WB(halt_MEM_WB),
        .imemaddr_MEM_WB(imemaddr_MEM_WB), .instruction_MEM_WB(instruction_MEM_WB),
        .mem_stall_cnt(mem_stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge; returns at the following negedge.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear();
        result_EX_MEM = '0; dmemstore_EX_MEM = '0;
        dmemREN = 0; dmemWEN = 0; WEN_EX_MEM = 0; halt_EX_MEM = 0;
        reg_dest_EX_MEM = '0; Rt_EX_MEM = '0; Rd_EX_MEM = '0;
        imemaddr_EX_MEM = '0; instruction_EX_MEM = '0;
        enable_MEM_WB = 1; flush_MEM_WB = 0;
        dc.dhit = 0; dc.dmemload = '0;
    endtask

    task automatic do_reset();
        clear();
        RST = 1;
        cyc();
        RST = 0;
    endtask

    initial begin
        int wen_n, st_n, early;
        RST = 1;
        clear();
        cyc();
        cyc();
        RST = 0;
        #1;
        chk("rst_wdat", wdat_MEM_WB, 0);
        chk("rst_wen", WEN_MEM_WB, 0);
        chk("rst_halt", halt_MEM_WB, 0);
        chk("rst_cnt", mem_stall_cnt, 0);
        chk("rst_dcren", dc.dcREN, 0);
        chk("rst_stall", stall_MEM, 0);

        // Load hitting in the issue cycle.
        dmemREN = 1; result_EX_MEM = 32'h100; dc.dhit = 1; dc.dmemload = 32'hDEADBEEF;
        reg_dest_EX_MEM = 0; Rt_EX_MEM = 5'd8; WEN_EX_MEM = 1;
        #1;
        chk("ld_dcren", dc.dcREN, 1);
        chk("ld_addr", dc.dmemaddr, 32'h100);
        chk("ld_stall", stall_MEM, 0);
        cyc();
        chk("ld_wdat", wdat_MEM_WB, 32'hDEADBEEF);
        chk("ld_wsel", wsel_MEM_WB, 8);
        chk("ld_wen", WEN_MEM_WB, 1);
        clear();

        // Store with dhit after 3 wait cycles.
        dmemWEN = 1; result_EX_MEM = 32'h200; dmemstore_EX_MEM = 32'hCAFE;
        instruction_EX_MEM = 32'hA5;
        wen_n = 0; st_n = 0; early = 0;
        for (int i = 0; i < 4; i++) begin
            dc.dhit = (i == 3);
            #1;
            if (i == 0) chk("st_data", dc.dmemstore, 32'hCAFE);
            if (dc.dcWEN) wen_n++;
            if (stall_MEM) st_n++;
            if (i < 3 && instruction_MEM_WB !== 32'h0) early++;
            cyc();
        end
        chk("st_dcwen_cycles", wen_n, 4);
        chk("st_stall_cycles", st_n, 3);
        chk("st_early_load", early, 0);
        chk("st_instr", instruction_MEM_WB, 32'hA5);
        chk("st_cnt", mem_stall_cnt, 3);
        clear();
        #1;
        chk("st_dcwen_off", dc.dcWEN, 0);

        // Counter saturation with further stalls.
        dmemREN = 1; result_EX_MEM = 32'h204;
        cyc();
        cyc();
        chk("cnt_sat", mem_stall_cnt, 3);
        dc.dhit = 1;
        cyc();
        clear();

        // Load completes while MEM/WB is frozen -> HOLD.
        do_reset();
        dmemREN = 1; dc.dhit = 1; dc.dmemload = 32'h1234; enable_MEM_WB = 0;
        reg_dest_EX_MEM = 1; Rd_EX_MEM = 5'd5; WEN_EX_MEM = 1;
        #1;
        chk("hold_dcren0", dc.dcREN, 1);
        cyc();
        dc.dhit = 0; dc.dmemload = 32'hFFFF;
        #1;
        chk("hold_dcren1", dc.dcREN, 0);
        chk("hold_stall", stall_MEM, 0);
        chk("hold_wen", WEN_MEM_WB, 0);
        cyc();
        enable_MEM_WB = 1;
        #1;
        chk("hold_dcren2", dc.dcREN, 0);
        cyc();
        chk("hold_wdat", wdat_MEM_WB, 32'h1234);
        chk("hold_wsel", wsel_MEM_WB, 5);
        chk("hold_wenout", WEN_MEM_WB, 1);
        clear();
        cyc();

        // Flush during a WAIT.
        WEN_EX_MEM = 1; result_EX_MEM = 32'h77; reg_dest_EX_MEM = 2;
        cyc();
        chk("alu_wdat", wdat_MEM_WB, 32'h77);
        chk("alu_wsel31", wsel_MEM_WB, 31);
        dmemREN = 1; result_EX_MEM = 32'h300; reg_dest_EX_MEM = 0; Rt_EX_MEM = 5'd3;
        flush_MEM_WB = 1;
        #1;
        chk("fl_stall", stall_MEM, 1);
        cyc();
        chk("fl_wen", WEN_MEM_WB, 0);
        chk("fl_wdat", wdat_MEM_WB, 0);
        chk("fl_wsel", wsel_MEM_WB, 0);
        flush_MEM_WB = 0;
        #1;
        chk("fl_dcren", dc.dcREN, 1);
        chk("fl_stall2", stall_MEM, 1);
        cyc();
        dc.dhit = 1; dc.dmemload = 32'hBEEF;
        #1;
        chk("fl_stall3", stall_MEM, 0);
        cyc();
        chk("fl_wdat2", wdat_MEM_WB, 32'hBEEF);
        chk("fl_wsel2", wsel_MEM_WB, 3);
        chk("fl_wen2", WEN_MEM_WB, 1);
        clear();
        #1;
        chk("fl_idle", dc.dcREN, 0);

        // Halt blocks the request and sticks through flushes.
        do_reset();
        halt_EX_MEM = 1; dmemWEN = 1; WEN_EX_MEM = 1;
        #1;
        chk("halt_dcwen", dc.dcWEN, 0);
        chk("halt_stall", stall_MEM, 0);
        cyc();
        chk("halt_set", halt_MEM_WB, 1);
        clear();
        flush_MEM_WB = 1;
        cyc();
        chk("halt_flush", halt_MEM_WB, 1);
        chk("halt_flush_wen", WEN_MEM_WB, 0);
        flush_MEM_WB = 0; WEN_EX_MEM = 1; result_EX_MEM = 32'h5;
        cyc();
        chk("halt_keep", halt_MEM_WB, 1);
        RST = 1;
        cyc();
        chk("halt_rst", halt_MEM_WB, 0);

        // Reset in the middle of a WAIT.
        RST = 0;
        clear();
        dmemREN = 1; result_EX_MEM = 32'h400; WEN_EX_MEM = 1;
        #1;
        chk("rw_stall", stall_MEM, 1);
        cyc();
        chk("rw_cnt1", mem_stall_cnt, 1);
        RST = 1;
        cyc();
        chk("rw_cnt0", mem_stall_cnt, 0);
        chk("rw_wdat", wdat_MEM_WB, 0);
        chk("rw_wen", WEN_MEM_WB, 0);
        RST = 0;
        clear();
        #1;
        chk("rw_dcren", dc.dcREN, 0);
        chk("rw_dcwen", dc.dcWEN, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
